seg7_scan_mux: RTL and testbench

- Downstream of seg7_driver. Consumes the packed per-display segment patterns (NUM_OF_DISPLAYS x 8 bits) and time-multiplexes them onto one shared active-low segment bus plus active-low digit anodes.
- Snapshots the pattern once per frame so digits never tear. Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/seg7_scan_mux.sv | 131 +++++++++++++
 tb/tb_seg7_scan_mux.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - time-multiplexed 7-segment scanner with per-frame snapshot and inter-digit blanking
// Optional: define SEG7_SCAN_DIM_EN to add brightness_i PWM dimming during DRIVE.
module seg7_scan_mux #(
    parameter int NUM_OF_DISPLAYS = 6,
    parameter int SCAN_DIV        = 1000,
    parameter int BLANK_CYCLES    = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               en_i,
`ifdef SEG7_SCAN_DIM_EN
    input  logic [3:0]                         brightness_i,
`endif
    input  logic [NUM_OF_DISPLAYS*8-1:0]       seg7_i,
    output logic [NUM_OF_DISPLAYS-1:0]         an_o,
    output logic [7:0]                         seg_o,
    output logic [$clog2(NUM_OF_DISPLAYS)-1:0] digit_o,
    output logic                               frame_o
);

    localparam int DW = $clog2(NUM_OF_DISPLAYS);
    localparam int TW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] T_LAST       = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] T_BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] D_LAST       = DW'(NUM_OF_DISPLAYS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;
    localparam state_t S_FIRST = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;

    state_t                       state_q;
    logic [DW-1:0]                digit_q;
    logic [TW-1:0]                timer_q;
    logic [NUM_OF_DISPLAYS*8-1:0] snap_q;
    logic [NUM_OF_DISPLAYS-1:0]   an_q, an_d;
    logic [7:0]                   seg_q, seg_d;
    logic                         frame_q;
    logic                         lit_d;

`ifdef SEG7_SCAN_DIM_EN
    logic [3:0] pwm_q;
    assign lit_d = (brightness_i == 4'hF) || (pwm_q < brightness_i);
`else
    assign lit_d = 1'b1;
`endif

    // Outputs follow the registered state one cycle later; en_i low blanks at once.
    always_comb begin
        an_d  = '1;
        seg_d = 8'hFF;
        if (en_i && state_q == S_DRIVE) begin
            seg_d = ~snap_q[int'(digit_q)*8 +: 8];
            if (lit_d) begin
                an_d[digit_q] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            digit_q <= '0;
            timer_q <= '0;
            snap_q  <= '0;
            an_q    <= '1;
            seg_q   <= 8'hFF;
            frame_q <= 1'b0;
`ifdef SEG7_SCAN_DIM_EN
            pwm_q   <= '0;
`endif
        end else begin
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= 1'b0;
            if (!en_i) begin
                state_q <= S_IDLE;
                digit_q <= '0;
                timer_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        snap_q  <= seg7_i;
                        digit_q <= '0;
                        timer_q <= '0;
                        frame_q <= 1'b1;
                        state_q <= S_FIRST;
`ifdef SEG7_SCAN_DIM_EN
                        pwm_q   <= '0;
`endif
                    end
                    S_BLANK: begin
                        timer_q <= timer_q + 1'b1;
                        if (timer_q == T_BLANK_LAST) begin
                            state_q <= S_DRIVE;
`ifdef SEG7_SCAN_DIM_EN
                            pwm_q   <= '0;
`endif
                        end
                    end
                    S_DRIVE: begin
`ifdef SEG7_SCAN_DIM_EN
                        pwm_q <= pwm_q + 1'b1;
`endif
                        if (timer_q == T_LAST) begin
                            timer_q <= '0;
                            state_q <= S_FIRST;
`ifdef SEG7_SCAN_DIM_EN
                            pwm_q   <= '0;
`endif
                            if (digit_q == D_LAST) begin
                                digit_q <= '0;
                                snap_q  <= seg7_i;
                                frame_q <= 1'b1;
                            end else begin
                                digit_q <= digit_q + 1'b1;
                            end
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign digit_o = digit_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - randomized bench for seg7_scan_mux against a position-based scan model
module tb_seg7_scan_mux;

    localparam int N  = 6;
    localparam int D  = 8;
    localparam int B  = 2;
    localparam int FP = N * D;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [N*8-1:0] seg7 = '0;
    logic [N-1:0]   an_a, an_b;
    logic [7:0]     seg_a, seg_b;
    logic [2:0]     dig_a, dig_b;
    logic           frm_a, frm_b;

    seg7_scan_mux #(.NUM_OF_DISPLAYS(N), .SCAN_DIV(D), .BLANK_CYCLES(B)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .seg7_i(seg7),
        .an_o(an_a), .seg_o(seg_a), .digit_o(dig_a), .frame_o(frm_a)
    );

    seg7_scan_mux #(.NUM_OF_DISPLAYS(N), .SCAN_DIV(D), .BLANK_CYCLES(0)) dut_nb (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .seg7_i(seg7),
        .an_o(an_b), .seg_o(seg_b), .digit_o(dig_b), .frame_o(frm_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: s counts edges since the enabling edge; frame f shows the pattern sampled at edge f*FP.
    logic [N*8-1:0] pats [int];
    bit             active = 1'b0;
    int             s = 0;

    function automatic void expect_pos(input int blank, input int pos,
                                       output logic [N-1:0] an_e, output logic [7:0] seg_e);
        int slot;
        logic [N*8-1:0] pat;
        slot  = (pos / D) % N;
        pat   = pats[pos / FP];
        an_e  = '1;
        seg_e = 8'hFF;
        if ((pos % D) >= blank) begin
            an_e[slot] = 1'b0;
            seg_e      = ~pat[slot*8 +: 8];
        end
    endfunction

    task automatic step();
        logic           rst_s, en_s;
        logic [N*8-1:0] seg_s;
        logic [N-1:0]   an_ea, an_eb;
        logic [7:0]     seg_ea, seg_eb;
        logic [2:0]     dig_e;
        logic           frm_e;
        rst_s = rst_n;
        en_s  = en;
        seg_s = seg7;
        @(posedge clk);
        #1;
        an_ea = '1; an_eb = '1; seg_ea = 8'hFF; seg_eb = 8'hFF;
        dig_e = '0; frm_e = 1'b0;
        if (!rst_s || !en_s) begin
            active = 1'b0;
        end else if (!active) begin
            active = 1'b1;
            s = 0;
            pats.delete();
            pats[0] = seg_s;
            frm_e = 1'b1;
        end else begin
            s++;
            if (s % FP == 0) begin
                pats[s / FP] = seg_s;
                frm_e = 1'b1;
            end
            dig_e = 3'((s / D) % N);
            expect_pos(B, s - 1, an_ea, seg_ea);
            expect_pos(0, s - 1, an_eb, seg_eb);
        end
        check("an", 64'(an_a), 64'(an_ea));
        check("seg", 64'(seg_a), 64'(seg_ea));
        check("digit", 64'(dig_a), 64'(dig_e));
        check("frame", 64'(frm_a), 64'(frm_e));
        check("an_nb", 64'(an_b), 64'(an_eb));
        check("seg_nb", 64'(seg_b), 64'(seg_eb));
        check("digit_nb", 64'(dig_b), 64'(dig_e));
        check("frame_nb", 64'(frm_b), 64'(frm_e));
        check("excl", 64'($countones(~an_a) <= 1), 64'd1);
        check("excl_nb", 64'($countones(~an_b) <= 1), 64'd1);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        en    = 1'b1;
        seg7  = {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D};
        repeat (5) step();
        rst_n = 1'b1;
        repeat (FP / 2) step();
        seg7[7:0] = 8'h3F;
        repeat (FP * 2) step();

        found = 1'b0;
        for (int i = 0; i < 4 * FP && !found; i++) begin
            if (active && ((s / D) % N) == 3 && (s % D) == 4) found = 1'b1;
            else step();
        end
        check("find_digit3", 64'(found), 64'd1);
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (FP + 4) step();

        for (int i = 0; i < 10 * FP; i++) begin
            seg7  = {$urandom, $urandom};
            en    = ($urandom_range(0, 149) != 0);
            rst_n = (i != 5 * FP);
            step();
        end
        en = 1'b1;
        rst_n = 1'b1;
        repeat (2 * FP) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
